// File: rtl/spi_frame_parser_if.sv
// Byte-stream handshake bundle for spi_frame_parser.
//   spi_iv/spi_id : one-cycle byte strobe and byte from the SPI slave (no backpressure)
//   out_ready     : downstream accepts out_d this cycle
//   out_v/out_d   : payload byte output and its valid
//   out_last      : marks the final payload byte of a frame (qualified by out_v)
// slave modport is the parser's view; master modport is the driver/consumer side.
interface spi_frame_parser_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  spi_iv;
  logic [DATA_WIDTH-1:0] spi_id;
  logic                  out_ready;
  logic                  out_v;
  logic [DATA_WIDTH-1:0] out_d;
  logic                  out_last;

  modport slave (
    input  spi_iv, spi_id, out_ready,
    output out_v, out_d, out_last
  );

  modport master (
    output spi_iv, spi_id, out_ready,
    input  out_v, out_d, out_last
  );
endinterface

// File: rtl/spi_frame_parser.sv
// Frame parser for bytes received over SPI.
// Frame: SYNC_BYTE, LEN, LEN payload bytes, CSUM; valid when
// (LEN + payload + CSUM) mod 2^DATA_WIDTH == 0. Good payloads are buffered and
// then streamed out with a valid/ready handshake; bad frames are discarded.
//   clk       : clock, rising edge
//   nrst      : asynchronous active-low reset
//   bus       : spi_frame_parser_if.slave (byte input, payload output)
//   crc_err   : one-cycle pulse on checksum mismatch
//   len_err   : one-cycle pulse on LEN == 0 or LEN > MAX_LEN
//   drop      : one-cycle pulse when a byte arrives while draining
//   frame_cnt : good-frame count, wraps 255 -> 0
module spi_frame_parser #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    MAX_LEN    = 16,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  nrst,
  spi_frame_parser_if.slave     bus,
  output logic                  crc_err,
  output logic                  len_err,
  output logic                  drop,
  output logic [7:0]            frame_cnt
);

  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [DATA_WIDTH-1:0] MAX_LEN_D = DATA_WIDTH'(MAX_LEN);

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_DRAIN
  } state_t;

  state_t                state, state_nxt;
  logic [PTR_W-1:0]      len_q, len_nxt;
  logic [PTR_W-1:0]      wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0]      rd_ptr, rd_ptr_nxt;
  logic [DATA_WIDTH-1:0] sum_q, sum_nxt;
  logic [DATA_WIDTH-1:0] csum_total;
  logic [7:0]            frame_cnt_nxt;
  logic                  crc_nxt, len_err_nxt, drop_nxt;
  logic                  buf_we;
  logic                  xfer;

  logic [DATA_WIDTH-1:0] mem [MAX_LEN];

  // Output stage reads straight from the buffer; only valid in DRAIN so that
  // reset forces out_d to zero without clearing the RAM.
  assign bus.out_v    = (state == ST_DRAIN);
  assign bus.out_last = bus.out_v && (rd_ptr == len_q - PTR_W'(1));
  assign bus.out_d    = bus.out_v ? mem[rd_ptr[IDX_W-1:0]] : '0;

  assign xfer       = bus.out_v && bus.out_ready;
  assign csum_total = sum_q + bus.spi_id;

  always_comb begin
    state_nxt     = state;
    len_nxt       = len_q;
    wr_ptr_nxt    = wr_ptr;
    rd_ptr_nxt    = rd_ptr;
    sum_nxt       = sum_q;
    frame_cnt_nxt = frame_cnt;
    crc_nxt       = 1'b0;
    len_err_nxt   = 1'b0;
    drop_nxt      = 1'b0;
    buf_we        = 1'b0;

    case (state)
      ST_HUNT: begin
        if (bus.spi_iv && bus.spi_id == SYNC_BYTE) begin
          state_nxt = ST_LEN;
        end
      end

      ST_LEN: begin
        if (bus.spi_iv) begin
          if (bus.spi_id == '0 || bus.spi_id > MAX_LEN_D) begin
            len_err_nxt = 1'b1;
            state_nxt   = ST_HUNT;
          end else begin
            len_nxt    = PTR_W'(bus.spi_id);
            // LEN is part of the checksum, so the cleared sum starts at LEN.
            sum_nxt    = bus.spi_id;
            wr_ptr_nxt = '0;
            state_nxt  = ST_PAYLOAD;
          end
        end
      end

      ST_PAYLOAD: begin
        if (bus.spi_iv) begin
          buf_we     = 1'b1;
          wr_ptr_nxt = wr_ptr + PTR_W'(1);
          sum_nxt    = sum_q + bus.spi_id;
          if (wr_ptr_nxt == len_q) begin
            state_nxt = ST_CSUM;
          end
        end
      end

      ST_CSUM: begin
        if (bus.spi_iv) begin
          if (csum_total == '0) begin
            frame_cnt_nxt = frame_cnt + 8'd1;
            rd_ptr_nxt    = '0;
            state_nxt     = ST_DRAIN;
          end else begin
            crc_nxt   = 1'b1;
            state_nxt = ST_HUNT;
          end
        end
      end

      ST_DRAIN: begin
        // Incoming bytes cannot be stalled, so they are discarded here,
        // including one that coincides with the final transfer.
        if (bus.spi_iv) begin
          drop_nxt = 1'b1;
        end
        if (xfer) begin
          rd_ptr_nxt = rd_ptr + PTR_W'(1);
          if (bus.out_last) begin
            state_nxt = ST_HUNT;
          end
        end
      end

      default: state_nxt = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= ST_HUNT;
      len_q     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      sum_q     <= '0;
      frame_cnt <= '0;
      crc_err   <= 1'b0;
      len_err   <= 1'b0;
      drop      <= 1'b0;
    end else begin
      state     <= state_nxt;
      len_q     <= len_nxt;
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      sum_q     <= sum_nxt;
      frame_cnt <= frame_cnt_nxt;
      crc_err   <= crc_nxt;
      len_err   <= len_err_nxt;
      drop      <= drop_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      mem[wr_ptr[IDX_W-1:0]] <= bus.spi_id;
    end
  end

endmodule

// File: tb/tb_spi_frame_parser.sv
module tb_spi_frame_parser;

  logic       clk;
  logic       nrst;
  logic       crc_err, len_err, drop;
  logic [7:0] frame_cnt;

  spi_frame_parser_if #(.DATA_WIDTH(8)) bus ();

  spi_frame_parser #(
    .DATA_WIDTH (8),
    .MAX_LEN    (16),
    .SYNC_BYTE  (8'hA5)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .bus       (bus),
    .crc_err   (crc_err),
    .len_err   (len_err),
    .drop      (drop),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Scoreboard entries are {last, data}.
  logic [8:0] sb [$];
  logic [7:0] pl [16];
  logic [7:0] exp_cnt = 8'd0;

  int crc_cnt = 0;
  int len_cnt = 0;
  int drop_cnt = 0;

  logic       stalled = 1'b0;
  logic [7:0] held = 8'd0;

  // Output monitor: pops the scoreboard on each transfer, checks hold while stalled.
  always @(negedge clk) begin
    if (!nrst) begin
      stalled <= 1'b0;
    end else begin
      if (stalled) begin
        total++;
        if (bus.out_v !== 1'b1 || bus.out_d !== held) begin
          bad++;
          $display("FAIL hold: out_v=%b out_d=%h required out_v=1 out_d=%h", bus.out_v, bus.out_d, held);
        end
      end
      if (bus.out_v === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out_v: out_v=1 out_d=%h required no output", bus.out_d);
        end else if (bus.out_ready === 1'b1) begin
          logic [8:0] e;
          e = sb.pop_front();
          total++;
          if ({bus.out_last, bus.out_d} !== e) begin
            bad++;
            $display("FAIL out_byte: last=%b d=%h required last=%b d=%h", bus.out_last, bus.out_d, e[8], e[7:0]);
          end
        end
      end
      stalled <= (bus.out_v === 1'b1) && (bus.out_ready !== 1'b1);
      held    <= bus.out_d;
      if (crc_err === 1'b1) crc_cnt++;
      if (len_err === 1'b1) len_cnt++;
      if (drop === 1'b1)    drop_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.spi_iv = 1'b1;
    bus.spi_id = b;
    @(posedge clk); #1;
    bus.spi_iv = 1'b0;
  endtask

  // Sends a frame with payload pl[0..n-1]; good frames are queued as expected output.
  task automatic send_frame(input int n, input bit corrupt);
    logic [7:0] s;
    s = 8'(n);
    for (int i = 0; i < n; i++) begin
      s = s + pl[i];
      if (!corrupt) sb.push_back({(i == n - 1), pl[i]});
    end
    if (!corrupt) exp_cnt = exp_cnt + 8'd1;
    send_byte(8'hA5);
    send_byte(8'(n));
    for (int i = 0; i < n; i++) send_byte(pl[i]);
    send_byte(corrupt ? (8'd1 - s) : (8'd0 - s));
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    bus.spi_iv = 1'b0;
    bus.spi_id = 8'h00;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.out_v, bus.out_last, bus.out_d, crc_err, len_err, drop, frame_cnt} !== 21'd0) begin
      bad++;
      $display("FAIL reset_state: v=%b last=%b d=%h crc=%b len=%b drop=%b cnt=%0d required all zero",
               bus.out_v, bus.out_last, bus.out_d, crc_err, len_err, drop, frame_cnt);
    end
    #3 nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_good_frame;
    bit ok;
    int c0, l0, d0;
    c0 = crc_cnt; l0 = len_cnt; d0 = drop_cnt;
    sb.push_back({1'b0, 8'h11});
    sb.push_back({1'b0, 8'h22});
    sb.push_back({1'b1, 8'h33});
    exp_cnt = exp_cnt + 8'd1;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h97);
    total++;
    if (bus.out_v !== 1'b1 || bus.out_d !== 8'h11) begin
      bad++;
      $display("FAIL good_latency: out_v=%b out_d=%h required out_v=1 out_d=11", bus.out_v, bus.out_d);
    end
    wait_drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL good_drain: timeout required queue empty"); end
    total++;
    if (bus.out_v !== 1'b0 || frame_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL good_end: out_v=%b cnt=%0d required out_v=0 cnt=%0d", bus.out_v, frame_cnt, exp_cnt);
    end
    total++;
    if (crc_cnt != c0 || len_cnt != l0 || drop_cnt != d0) begin
      bad++;
      $display("FAIL good_flags: crc=%0d len=%0d drop=%0d required %0d %0d %0d", crc_cnt, len_cnt, drop_cnt, c0, l0, d0);
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    bus.out_ready = 1'b1;
    send_frame(3, 1'b0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      total++;
      if (bus.out_v !== 1'b1 || bus.out_d !== 8'h22 || bus.out_last !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold: v=%b d=%h last=%b required v=1 d=22 last=0", bus.out_v, bus.out_d, bus.out_last);
      end
    end
    bus.out_ready = 1'b1;
    wait_drain(ok);
    total++;
    if (!ok || frame_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL bp_end: ok=%b cnt=%0d required ok=1 cnt=%0d", ok, frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_bad_csum;
    bit ok;
    int c0;
    c0 = crc_cnt;
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_frame(3, 1'b1);
    total++;
    if (crc_err !== 1'b1) begin bad++; $display("FAIL crc_pulse: crc_err=%b required 1", crc_err); end
    @(posedge clk); #1;
    total++;
    if (crc_err !== 1'b0 || bus.out_v !== 1'b0) begin
      bad++;
      $display("FAIL crc_after: crc_err=%b out_v=%b required 0 0", crc_err, bus.out_v);
    end
    total++;
    if (crc_cnt != c0 + 1 || frame_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL crc_count: pulses=%0d cnt=%0d required %0d %0d", crc_cnt - c0, frame_cnt, 1, exp_cnt);
    end
    pl[0] = 8'h5C; pl[1] = 8'hA5;
    send_frame(2, 1'b0);
    wait_drain(ok);
    total++;
    if (!ok || frame_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL crc_recover: ok=%b cnt=%0d required ok=1 cnt=%0d", ok, frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_len_err;
    bit ok;
    int c0, l0, d0;
    logic [7:0] bad_len [2];
    c0 = crc_cnt; l0 = len_cnt; d0 = drop_cnt;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    @(posedge clk); #1;
    total++;
    if (crc_cnt != c0 || len_cnt != l0 || drop_cnt != d0) begin
      bad++;
      $display("FAIL noise_flags: crc=%0d len=%0d drop=%0d required %0d %0d %0d", crc_cnt, len_cnt, drop_cnt, c0, l0, d0);
    end
    bad_len[0] = 8'h00; bad_len[1] = 8'h11;
    for (int k = 0; k < 2; k++) begin
      send_byte(8'hA5);
      send_byte(bad_len[k]);
      total++;
      if (len_err !== 1'b1) begin bad++; $display("FAIL len_pulse: len=%h len_err=%b required 1", bad_len[k], len_err); end
      @(posedge clk); #1;
      total++;
      if (len_err !== 1'b0) begin bad++; $display("FAIL len_after: len=%h len_err=%b required 0", bad_len[k], len_err); end
    end
    total++;
    if (len_cnt != l0 + 2) begin bad++; $display("FAIL len_count: pulses=%0d required 2", len_cnt - l0); end
    pl[0] = 8'h42;
    send_frame(1, 1'b0);
    wait_drain(ok);
    total++;
    if (!ok || frame_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL len_recover: ok=%b cnt=%0d required ok=1 cnt=%0d", ok, frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_drop;
    bit ok;
    int d0;
    d0 = drop_cnt;
    pl[0] = 8'h01; pl[1] = 8'h02;
    bus.out_ready = 1'b0;
    send_frame(2, 1'b0);
    send_byte(8'h5A);
    total++;
    if (drop !== 1'b1) begin bad++; $display("FAIL drop_pulse1: drop=%b required 1", drop); end
    send_byte(8'hA5);
    total++;
    if (drop !== 1'b1) begin bad++; $display("FAIL drop_pulse2: drop=%b required 1", drop); end
    @(posedge clk); #1;
    total++;
    if (drop !== 1'b0 || drop_cnt != d0 + 2 || bus.out_d !== 8'h01) begin
      bad++;
      $display("FAIL drop_after: drop=%b pulses=%0d d=%h required 0 2 01", drop, drop_cnt - d0, bus.out_d);
    end
    bus.out_ready = 1'b1;
    wait_drain(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL drop_drain: timeout required queue empty"); end
  endtask

  // A byte coinciding with the final transfer is dropped and HUNT starts next cycle.
  task automatic test_back_to_back;
    bit ok;
    int d0;
    pl[0] = 8'h77;
    send_frame(1, 1'b0);
    d0 = drop_cnt;
    send_byte(8'hA5);
    total++;
    if (drop !== 1'b1 || bus.out_v !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drop: drop=%b out_v=%b required 1 0", drop, bus.out_v);
    end
    pl[0] = 8'h10; pl[1] = 8'h20; pl[2] = 8'h30; pl[3] = 8'h40;
    send_frame(4, 1'b0);
    wait_drain(ok);
    total++;
    if (!ok || frame_cnt !== exp_cnt || drop_cnt != d0 + 1) begin
      bad++;
      $display("FAIL b2b_end: ok=%b cnt=%0d drops=%0d required ok=1 cnt=%0d drops=1", ok, frame_cnt, drop_cnt - d0, exp_cnt);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    send_byte(8'hA5); send_byte(8'h05); send_byte(8'h01); send_byte(8'h02);
    #2 nrst = 1'b0;
    #1;
    total++;
    if ({bus.out_v, bus.out_last, bus.out_d, crc_err, len_err, drop, frame_cnt} !== 21'd0) begin
      bad++;
      $display("FAIL reset_mid: v=%b last=%b d=%h crc=%b len=%b drop=%b cnt=%0d required all zero",
               bus.out_v, bus.out_last, bus.out_d, crc_err, len_err, drop, frame_cnt);
    end
    exp_cnt = 8'd0;
    @(posedge clk); #2 nrst = 1'b1;
    @(posedge clk); #1;
    pl[0] = 8'hDE; pl[1] = 8'hAD; pl[2] = 8'hBE;
    send_frame(3, 1'b0);
    wait_drain(ok);
    total++;
    if (!ok || frame_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL reset_recover: ok=%b cnt=%0d required ok=1 cnt=%0d", ok, frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_max_len;
    bit ok;
    for (int i = 0; i < 16; i++) pl[i] = 8'(i * 7 + 3);
    send_frame(16, 1'b0);
    wait_drain(ok);
    total++;
    if (!ok || bus.out_v !== 1'b0 || frame_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL max_len: ok=%b out_v=%b cnt=%0d required ok=1 out_v=0 cnt=%0d", ok, bus.out_v, frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_wrap;
    bit ok;
    bit all_ok;
    logic [7:0] start;
    start = exp_cnt;
    all_ok = 1'b1;
    for (int k = 0; k < 256; k++) begin
      pl[0] = 8'(k);
      send_frame(1, 1'b0);
      wait_drain(ok);
      if (!ok) all_ok = 1'b0;
    end
    total++;
    if (!all_ok || frame_cnt !== start) begin
      bad++;
      $display("FAIL wrap: ok=%b cnt=%0d required ok=1 cnt=%0d", all_ok, frame_cnt, start);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_backpressure();
    test_bad_csum();
    test_len_err();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    test_max_len();
    test_wrap();
    repeat (3) @(posedge clk);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover: entries=%0d required 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_frame_parser.md
SPI_FRAME_PARSER -- requirements
Module: spi_frame_parser

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of received bytes and output data.
REQ-002 Parameter MAX_LEN, default 16: maximum payload length in bytes; also the payload buffer depth.
REQ-003 Parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-004 clk  input  1  sole clock; all logic on the rising edge.
REQ-005 nrst  input  1  reset, asynchronous assert, active-low.
REQ-006 spi_iv  input  1  byte-valid strobe from spi_slave (spi_ov); one-cycle pulse per byte; no backpressure exists.
REQ-007 spi_id  input  DATA_WIDTH  received byte (spi_od); sampled only when spi_iv=1.
REQ-008 out_ready  input  1  downstream accepts out_d this cycle.
REQ-009 out_v  output  1  out_d valid.
REQ-010 out_d  output  DATA_WIDTH  payload byte.
REQ-011 out_last  output  1  qualifies the final payload byte of a frame; meaningful only with out_v.
REQ-012 crc_err  output  1  one-cycle pulse: checksum mismatch.
REQ-013 len_err  output  1  one-cycle pulse: illegal length byte.
REQ-014 drop  output  1  one-cycle pulse: byte discarded while draining.
REQ-015 frame_cnt  output  8  count of good frames, wraps 255->0.

Function
REQ-016 Frame format, in byte order: SYNC_BYTE, LEN, LEN payload bytes, CSUM.
REQ-017 Valid CSUM: (LEN + all payload bytes + CSUM) mod 256 == 0.
REQ-018 State machine states: HUNT, LEN, PAYLOAD, CSUM, DRAIN. Transitions occur only on spi_iv=1, except exits from DRAIN.
REQ-019 HUNT: byte==SYNC_BYTE -> LEN; any other byte is ignored silently and no flag pulses.
REQ-020 LEN: LEN==0 or LEN>MAX_LEN -> len_err pulse next cycle, return to HUNT; otherwise latch LEN, clear running sum and write pointer, go to PAYLOAD.
REQ-021 PAYLOAD: write byte to buffer[wr_ptr], wr_ptr++, add byte to the 8-bit running sum (mod 256); when LEN bytes are stored -> CSUM.
REQ-022 A payload byte equal to SYNC_BYTE is treated as data; there is no resync inside a frame.
REQ-023 CSUM on mismatch: crc_err pulses the cycle after the CSUM byte; return to HUNT; buffer contents are discarded and nothing is output.
REQ-024 CSUM on match: go to DRAIN; frame_cnt increments once; out_v asserts the cycle after the CSUM byte is sampled (latency 1).
REQ-025 DRAIN: out_d=buffer[rd_ptr]; a byte transfers when out_v&&out_ready; rd_ptr advances by one per transfer, so at most one byte per cycle.
REQ-026 out_v and out_d hold stable while out_ready=0.
REQ-027 out_last=1 exactly when rd_ptr==LEN-1.
REQ-028 On transfer of the last byte: out_v deasserts next cycle and the state returns to HUNT.
REQ-029 spi_iv=1 while in DRAIN: the byte is discarded, drop pulses the next cycle, and state is unchanged.
REQ-030 A byte arriving in the same cycle as the final DRAIN transfer is also dropped; HUNT begins the following cycle.
REQ-031 crc_err, len_err and drop are registered and each stays high for exactly one cycle per event.
REQ-032 The buffer is a single bank of MAX_LEN x DATA_WIDTH; pointer width is clog2(MAX_LEN)+1.

Reset
REQ-033 nrst=0 immediately forces: state=HUNT, out_v=0, out_last=0, out_d=0, crc_err=0, len_err=0, drop=0, frame_cnt=0, pointers=0, sum=0.
REQ-034 Reset asserted mid-frame or mid-drain abandons the frame with no flag pulses; buffer RAM contents need not be cleared.
REQ-035 After nrst rises, the first byte is evaluated in HUNT.

Verification
REQ-036 Good frame: bytes A5 03 11 22 33 97, out_ready=1 -> out_d 11,22,33 on consecutive cycles starting 1 cycle after 97; out_last only with 33; frame_cnt=1.
REQ-037 Backpressure: same frame, out_ready low for 3 cycles on byte 22 -> 22 held stable, no loss; out_last with 33.
REQ-038 Bad checksum: A5 03 11 22 33 98 -> crc_err one pulse, out_v never asserts, frame_cnt unchanged; a following good frame parses normally.
REQ-039 Length errors: A5 00 and A5 11 (MAX_LEN=16) -> len_err one pulse each, back to HUNT; noise bytes 00 FF 5A before A5 are ignored with no flags.
REQ-040 Drop and reset: 2 bytes arriving during DRAIN with out_ready=0 -> 2 drop pulses, output frame intact; nrst pulse mid-PAYLOAD -> all outputs at reset values, next good frame parses.
REQ-041 Wrap and boundary: 256 good frames -> frame_cnt=0; frame with LEN=16 -> all 16 bytes output, last with out_last.
